// File: rtl/led_div_ctrl.sv
// led_div_ctrl: push-button control for the LED divider select.
//   Two raw buttons are synchronized, debounced and turned into step events.
//   A button held down keeps stepping at a fixed auto-repeat period.
//   Up steps raise div_o and down steps lower it, saturating at 31 and 0.
// Ports:
//   clk100   - system clock (the only clock)
//   rst_n    - active-low reset; asserts asynchronously, releases synchronously
//   btn_up_i - raw up button, active-high, asynchronous, bouncy
//   btn_dn_i - raw down button, active-high, asynchronous, bouncy
//   div_o    - registered divider select, DIV_INIT after reset
//   chg_o    - one-cycle pulse in the first cycle div_o shows a new value

// led_btn_chan: the path from one raw button to its step events.
//   The button passes through a 2-flop synchronizer and then a debouncer.
//   step_o is a registered one-cycle pulse. It fires once on the press and
//   then again every RPT_CYCLES while the button stays held.
// Ports:
//   clk100 - system clock
//   rst_n  - synchronized active-low reset
//   btn_i  - raw button input
//   step_o - step event
module led_btn_chan #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned RPT_CYCLES = 30000000
) (
  input  logic clk100,
  input  logic rst_n,
  input  logic btn_i,
  output logic step_o
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RPT_W = (RPT_CYCLES > 1) ? $clog2(RPT_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             lvl;
  logic             lvl_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rise;
  logic             rpt_hit;

  assign rise = lvl & ~lvl_prev;
  // The repeat counter is held at zero during the rise cycle.
  // This makes the first repeat land exactly RPT_CYCLES after the initial step.
  assign rpt_hit = lvl & (rpt_cnt == RPT_LAST);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      lvl      <= 1'b0;
      lvl_prev <= 1'b0;
      deb_cnt  <= '0;
      rpt_cnt  <= '0;
      step_o   <= 1'b0;
    end else begin
      sync1    <= btn_i;
      sync2    <= sync1;
      lvl_prev <= lvl;

      // Any cycle of agreement restarts qualification.
      if (sync2 == lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        lvl     <= ~lvl;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end

      if (!lvl || rise || rpt_hit) begin
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end

      step_o <= rise | rpt_hit;
    end
  end

endmodule

module led_div_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned RPT_CYCLES = 30000000,
  parameter logic [4:0]  DIV_INIT   = 5'd24
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  output logic [4:0] div_o,
  output logic       chg_o
);

  logic rst_meta;
  logic rst_sync;
  logic step_up;
  logic step_dn;

  // Reset asserts asynchronously and releases on the clock.
  // The release takes two edges to reach the rest of the logic.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  led_btn_chan #(
    .DEB_CYCLES(DEB_CYCLES),
    .RPT_CYCLES(RPT_CYCLES)
  ) u_chan_up (
    .clk100(clk100),
    .rst_n (rst_sync),
    .btn_i (btn_up_i),
    .step_o(step_up)
  );

  led_btn_chan #(
    .DEB_CYCLES(DEB_CYCLES),
    .RPT_CYCLES(RPT_CYCLES)
  ) u_chan_dn (
    .clk100(clk100),
    .rst_n (rst_sync),
    .btn_i (btn_dn_i),
    .step_o(step_dn)
  );

  // An up step and a down step in the same cycle cancel each other.
  // A step at a saturation limit is silent: div_o holds and chg_o stays low.
  always_ff @(posedge clk100 or negedge rst_sync) begin
    if (!rst_sync) begin
      div_o <= DIV_INIT;
      chg_o <= 1'b0;
    end else begin
      chg_o <= 1'b0;
      if (step_up && !step_dn && (div_o != 5'd31)) begin
        div_o <= div_o + 5'd1;
        chg_o <= 1'b1;
      end else if (step_dn && !step_up && (div_o != 5'd0)) begin
        div_o <= div_o - 5'd1;
        chg_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_div_ctrl.sv
// tb_led_div_ctrl: directed and randomized button scenarios for led_div_ctrl.
//   Expected values come from a rule-level reference model and from fixed constants.
module tb_led_div_ctrl;

  localparam int         DEB  = 4;
  localparam int         RPT  = 20;
  localparam logic [4:0] INIT = 5'd24;

  logic       clk100   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       btn_up_i = 1'b0;
  logic       btn_dn_i = 1'b0;
  logic [4:0] div_o;
  logic       chg_o;

  int checks   = 0;
  int failures = 0;

  led_div_ctrl #(
    .DEB_CYCLES(DEB),
    .RPT_CYCLES(RPT),
    .DIV_INIT  (INIT)
  ) dut (
    .clk100  (clk100),
    .rst_n   (rst_n),
    .btn_up_i(btn_up_i),
    .btn_dn_i(btn_dn_i),
    .div_o   (div_o),
    .chg_o   (chg_o)
  );

  always #5 clk100 = ~clk100;

  // Reference model. Index 0 is the up button and index 1 is the down button.
  //   hold   - edges still swallowed by the reset release
  //   p1, p2 - the two synchronizer stages
  //   run    - consecutive cycles the synced input has disagreed with the level
  //   rise   - edge index at which the level last went high
  //   gen    - step event raised at the previous edge, applied at this edge
  int hold   = 2;
  int n_edge = 0;
  bit p1[2];
  bit p2[2];
  bit lvl[2];
  bit gen[2];
  int run[2];
  int rise[2];
  int m_div  = INIT;
  bit m_chg  = 1'b0;

  always @(posedge clk100 or negedge rst_n) begin
    bit raw[2];
    bit ng[2];
    bit s;
    if (!rst_n) begin
      hold  = 2;
      m_div = INIT;
      m_chg = 1'b0;
      for (int b = 0; b < 2; b++) begin
        p1[b] = 0; p2[b] = 0; lvl[b] = 0; gen[b] = 0; run[b] = 0; rise[b] = 0;
      end
    end else if (hold > 0) begin
      hold--;
    end else begin
      n_edge++;
      raw[0] = btn_up_i;
      raw[1] = btn_dn_i;
      for (int b = 0; b < 2; b++) begin
        s     = p2[b];
        p2[b] = p1[b];
        p1[b] = raw[b];
        // A held button steps one edge after its rise, then every RPT edges.
        ng[b] = lvl[b] && (((n_edge - rise[b] - 1) % RPT) == 0);
        if (s != lvl[b]) begin
          run[b]++;
          if (run[b] == DEB) begin
            lvl[b] = !lvl[b];
            run[b] = 0;
            if (lvl[b]) rise[b] = n_edge;
          end
        end else begin
          run[b] = 0;
        end
      end
      m_chg = 1'b0;
      if (gen[0] && !gen[1] && m_div < 31) begin
        m_div++; m_chg = 1'b1;
      end else if (gen[1] && !gen[0] && m_div > 0) begin
        m_div--; m_chg = 1'b1;
      end
      gen = ng;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; btn_up_i = 1'b0; btn_dn_i = 1'b0;
    repeat (3) @(negedge clk100);
    checks++;
    if (div_o !== INIT || chg_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state div=%0d chg=%0b expected div=%0d chg=0", div_o, chg_o, INIT);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk100);
      checks++;
      if (div_o !== INIT || chg_o !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset cyc=%0d div=%0d chg=%0b expected div=%0d chg=0", i, div_o, chg_o, INIT);
      end
    end
  endtask

  task automatic test_glitch_filter;
    int first  = 0;
    int pulses = 0;
    for (int k = 0; k < 5; k++) begin
      btn_up_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (i == 3) btn_up_i = 1'b0;
        @(negedge clk100);
        checks++;
        if (div_o !== 5'(m_div) || chg_o !== m_chg) begin
          failures++;
          $display("FAIL glitch_model div=%0d chg=%0b expected div=%0d chg=%0b", div_o, chg_o, m_div, m_chg);
        end
      end
    end
    repeat (10) @(negedge clk100);
    checks++;
    if (div_o !== INIT) begin
      failures++;
      $display("FAIL glitch_rejected div=%0d expected %0d", div_o, INIT);
    end
    btn_up_i = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) btn_up_i = 1'b0;
      @(negedge clk100);
      checks++;
      if (div_o !== 5'(m_div) || chg_o !== m_chg) begin
        failures++;
        $display("FAIL press_model cyc=%0d div=%0d chg=%0b expected div=%0d chg=%0b", i, div_o, chg_o, m_div, m_chg);
      end
      if (chg_o === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    checks++;
    if (pulses != 1 || first != 8 || div_o !== 5'd25) begin
      failures++;
      $display("FAIL press_latency pulses=%0d first=%0d div=%0d expected pulses=1 first=8 div=25", pulses, first, div_o);
    end
  endtask

  task automatic test_auto_repeat;
    int idx[$];
    rst_n = 1'b0;
    @(negedge clk100);
    rst_n = 1'b1;
    repeat (5) @(negedge clk100);
    btn_dn_i = 1'b1;
    for (int i = 1; i <= 135; i++) begin
      if (i == 76) btn_dn_i = 1'b0;
      @(negedge clk100);
      checks++;
      if (div_o !== 5'(m_div) || chg_o !== m_chg) begin
        failures++;
        $display("FAIL repeat_model cyc=%0d div=%0d chg=%0b expected div=%0d chg=%0b", i, div_o, chg_o, m_div, m_chg);
      end
      if (chg_o === 1'b1) idx.push_back(i);
    end
    checks++;
    if (idx.size() != 4 || div_o !== 5'd20) begin
      failures++;
      $display("FAIL repeat_count pulses=%0d div=%0d expected pulses=4 div=20", idx.size(), div_o);
    end
    for (int k = 1; k < idx.size(); k++) begin
      checks++;
      if (idx[k] - idx[k-1] != RPT) begin
        failures++;
        $display("FAIL repeat_spacing k=%0d got=%0d expected=%0d", k, idx[k] - idx[k-1], RPT);
      end
    end
  endtask

  task automatic test_saturation;
    int pulses;
    int hold_len;
    rst_n = 1'b0;
    @(negedge clk100);
    rst_n = 1'b1;
    repeat (5) @(negedge clk100);
    // Seven presses take 24 to 31. The eighth press lands on the ceiling.
    for (int phase = 0; phase < 4; phase++) begin
      int n_press;
      bit up;
      case (phase)
        0:       begin n_press = 7;  up = 1'b1; end
        1:       begin n_press = 1;  up = 1'b1; end
        2:       begin n_press = 6;  up = 1'b0; end
        default: begin n_press = 27; up = 1'b0; end
      endcase
      pulses = 0;
      for (int p = 0; p < n_press; p++) begin
        hold_len = $urandom_range(5, 16);
        if (up) btn_up_i = 1'b1; else btn_dn_i = 1'b1;
        for (int i = 0; i < hold_len + 12; i++) begin
          if (i == hold_len) begin btn_up_i = 1'b0; btn_dn_i = 1'b0; end
          @(negedge clk100);
          checks++;
          if (div_o !== 5'(m_div) || chg_o !== m_chg) begin
            failures++;
            $display("FAIL sat_model phase=%0d div=%0d chg=%0b expected div=%0d chg=%0b", phase, div_o, chg_o, m_div, m_chg);
          end
          if (chg_o === 1'b1) pulses++;
        end
      end
      checks++;
      case (phase)
        0: if (pulses != 7 || div_o !== 5'd31) begin
             failures++;
             $display("FAIL sat_load pulses=%0d div=%0d expected pulses=7 div=31", pulses, div_o);
           end
        1: if (pulses != 0 || div_o !== 5'd31) begin
             failures++;
             $display("FAIL sat_ceiling pulses=%0d div=%0d expected pulses=0 div=31", pulses, div_o);
           end
        2: if (pulses != 6 || div_o !== 5'd25) begin
             failures++;
             $display("FAIL sat_down6 pulses=%0d div=%0d expected pulses=6 div=25", pulses, div_o);
           end
        default: if (pulses != 25 || div_o !== 5'd0) begin
             failures++;
             $display("FAIL sat_floor pulses=%0d div=%0d expected pulses=25 div=0", pulses, div_o);
           end
      endcase
    end
  endtask

  task automatic test_both_held;
    int pulses = 0;
    rst_n = 1'b0;
    @(negedge clk100);
    rst_n = 1'b1;
    repeat (5) @(negedge clk100);
    btn_up_i = 1'b1;
    btn_dn_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 30) begin btn_up_i = 1'b0; btn_dn_i = 1'b0; end
      @(negedge clk100);
      checks++;
      if (div_o !== 5'(m_div) || chg_o !== m_chg) begin
        failures++;
        $display("FAIL both_model div=%0d chg=%0b expected div=%0d chg=%0b", div_o, chg_o, m_div, m_chg);
      end
      if (chg_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || div_o !== INIT) begin
      failures++;
      $display("FAIL both_cancel pulses=%0d div=%0d expected pulses=0 div=%0d", pulses, div_o, INIT);
    end
  endtask

  task automatic test_reset_mid_repeat;
    int  first   = 0;
    bit  reached = 1'b0;
    rst_n = 1'b0;
    @(negedge clk100);
    rst_n = 1'b1;
    repeat (5) @(negedge clk100);
    // Walk down to 9 and release. Then hold up: the initial step reaches 10.
    btn_dn_i = 1'b1;
    for (int i = 0; i < 400 && !reached; i++) begin
      @(negedge clk100);
      if (div_o === 5'd9) reached = 1'b1;
    end
    btn_dn_i = 1'b0;
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL reach_nine timeout div=%0d expected 9", div_o);
    end
    repeat (15) @(negedge clk100);
    btn_up_i = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(negedge clk100);
      if (div_o === 5'd10) reached = 1'b1;
    end
    repeat (7) @(negedge clk100);
    checks++;
    if (!reached || div_o !== 5'd10 || div_o !== 5'(m_div)) begin
      failures++;
      $display("FAIL reach_ten div=%0d model=%0d expected 10", div_o, m_div);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (div_o !== INIT || chg_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset div=%0d chg=%0b expected div=%0d chg=0", div_o, chg_o, INIT);
    end
    repeat (3) @(negedge clk100);
    rst_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk100);
      checks++;
      if (div_o !== 5'(m_div) || chg_o !== m_chg) begin
        failures++;
        $display("FAIL rel_model cyc=%0d div=%0d chg=%0b expected div=%0d chg=%0b", i, div_o, chg_o, m_div, m_chg);
      end
      if (chg_o === 1'b1 && first == 0) first = i;
    end
    checks++;
    if (first != 10 || div_o !== 5'd25) begin
      failures++;
      $display("FAIL rel_latency first=%0d div=%0d expected first=10 div=25", first, div_o);
    end
    btn_up_i = 1'b0;
    repeat (12) @(negedge clk100);
  endtask

  task automatic test_random;
    int left[2];
    rst_n = 1'b0;
    @(negedge clk100);
    rst_n = 1'b1;
    left[0] = 0;
    left[1] = 0;
    for (int i = 0; i < 1200; i++) begin
      for (int b = 0; b < 2; b++) begin
        if (left[b] == 0) begin
          left[b] = $urandom_range(1, 45);
          if (b == 0) btn_up_i = ~btn_up_i; else btn_dn_i = ~btn_dn_i;
        end
        left[b]--;
      end
      @(negedge clk100);
      checks++;
      if (div_o !== 5'(m_div) || chg_o !== m_chg) begin
        failures++;
        $display("FAIL random_model cyc=%0d div=%0d chg=%0b expected div=%0d chg=%0b", i, div_o, chg_o, m_div, m_chg);
      end
    end
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch_filter();
    test_auto_repeat();
    test_saturation();
    test_both_held();
    test_reset_mid_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_div_ctrl.md
LED_DIV_CTRL -- requirements
Module: led_div_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000: debounce qualification length in clk100 cycles (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter RPT_CYCLES, default 30000000: auto-repeat period in clk100 cycles while a button is held; legal range 2..2^25-1.
REQ-003 Parameter DIV_INIT, default 5'd24: div_o value after reset.
REQ-004 clk100  input  1  system clock, 100 MHz; the only clock; all state on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 btn_up_i  input  1  raw push-button, active-high, asynchronous to clk100, bouncy.
REQ-007 btn_dn_i  input  1  raw push-button, active-high, asynchronous to clk100, bouncy.
REQ-008 div_o  output  5  divider select; drives div_i of the downstream LED counter stage.
REQ-009 chg_o  output  1  one-cycle pulse, high in the cycle div_o first shows a new value.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL have an independent debouncer: a debounced level register plus counter; the counter clears whenever the synced input equals the debounced level.
REQ-012 The debounced level SHALL toggle on the edge where the synced input has differed from it for DEB_CYCLES consecutive cycles; the counter clears on the same edge.
REQ-013 Any single-cycle agreement between the synced input and the debounced level SHALL restart qualification from zero.
REQ-014 A step event SHALL be generated for the cycle after the debounced level rises 0->1; no event on a 1->0 transition.
REQ-015 Auto-repeat: while the debounced level is high, a per-button repeat counter SHALL count from the rise; each time it reaches RPT_CYCLES it SHALL generate one further step event and restart; it SHALL clear when the debounced level falls.
REQ-016 An up step SHALL increment div_o by 1, saturating at 31; a down step SHALL decrement by 1, saturating at 0; no wrap-around.
REQ-017 Up and down step events in the same cycle SHALL cancel: div_o unchanged, chg_o low.
REQ-018 div_o and chg_o SHALL be registered, updating on the edge after the step event, i.e. two edges after the debounced-level edge of REQ-012.
REQ-019 chg_o SHALL pulse only when div_o actually changes; a step at a saturation limit SHALL leave chg_o low.
REQ-020 Both buttons held: each produces its own initial and repeat events; coincident events follow REQ-017, and non-coincident events apply individually.
REQ-021 Counters SHALL be sized by clog2 of their parameter and SHALL never overflow.

Reset
REQ-022 rst_n low SHALL asynchronously force: synchronizers 0, debounced levels 0, all counters 0, div_o = DIV_INIT, chg_o = 0.
REQ-023 Reset deassertion SHALL be synchronized to clk100 (async assert, sync release) before it reaches the logic.
REQ-024 A button held through reset release SHALL be treated as a fresh press: a step occurs after full debounce qualification, never immediately.
REQ-025 Reset mid-debounce or mid-repeat SHALL discard all partial counts; no step is generated for that activity.

Verification (bench parameters: DEB_CYCLES=4, RPT_CYCLES=20, DIV_INIT=24)
REQ-026 Reset release, no buttons, 100 cycles -> div_o=24 throughout, chg_o never high.
REQ-027 btn_up_i glitches high 3 cycles then low, repeated 5 times -> div_o stays 24; then held high 10 cycles -> div_o=25 with a single chg_o pulse, exactly 2+4+2 edges after the first synced-high sample.
REQ-028 btn_dn_i held 75 cycles from div_o=24 -> div_o 23, then 22, 21, 20 at 20-cycle spacing, with 4 chg_o pulses; release -> no further change.
REQ-029 Load 31 via repeated up presses, then press up again -> div_o=31, chg_o low; 25 down presses from 25 -> floor at 0 with exactly 25 chg_o pulses.
REQ-030 Both buttons driven high in the same cycle and held 30 cycles -> initial and repeat events coincide, div_o unchanged, chg_o never high.
REQ-031 rst_n pulsed low mid-repeat with div_o=10 and btn_up_i still held -> div_o=24 immediately (asynchronous), then 25 only after full debounce following synchronized reset release.
